// File: rtl/fb_write_scheduler_if.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler_if
//
// Bundles every handshake and bus signal of the frame-buffer write scheduler.
//
//   Rasterizer request : rast_valid, rast_x, rast_y, rast_color -> rast_ready
//   Host request       : host_valid, host_x, host_y, host_color -> host_ready
//   Clear control      : clr_start, clr_color -> clr_busy, clr_done
//   Frame buffer port  : fb_we, fb_addr, fb_data
//   Status             : drop_cnt (out-of-range requests dropped)
//
// Modports:
//   master : the requester side (rasterizer, host, clear control).
//   slave  : the scheduler itself.
// -----------------------------------------------------------------------------
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 4,
    parameter int X_W    = 9,
    parameter int Y_W    = 8
);
    logic              rast_valid;
    logic              rast_ready;
    logic [X_W-1:0]    rast_x;
    logic [Y_W-1:0]    rast_y;
    logic [PIX_W-1:0]  rast_color;

    logic              host_valid;
    logic              host_ready;
    logic [X_W-1:0]    host_x;
    logic [Y_W-1:0]    host_y;
    logic [PIX_W-1:0]  host_color;

    logic              clr_start;
    logic [PIX_W-1:0]  clr_color;
    logic              clr_busy;
    logic              clr_done;

    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;

    logic [15:0]       drop_cnt;

    modport master (
        output rast_valid, rast_x, rast_y, rast_color,
        output host_valid, host_x, host_y, host_color,
        output clr_start, clr_color,
        input  rast_ready, host_ready,
        input  clr_busy, clr_done,
        input  fb_we, fb_addr, fb_data,
        input  drop_cnt
    );

    modport slave (
        input  rast_valid, rast_x, rast_y, rast_color,
        input  host_valid, host_x, host_y, host_color,
        input  clr_start, clr_color,
        output rast_ready, host_ready,
        output clr_busy, clr_done,
        output fb_we, fb_addr, fb_data,
        output drop_cnt
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler
//
// Write-side controller for the 320x240, 4-bit frame buffer GPU write port.
// Round-robin arbitration between rasterizer and host pixel writes
// (valid/ready), (x,y) -> linear address conversion, and a full-screen clear
// sequencer that owns the write port while it runs.
//
// Ports:
//   gpu_clk    : clock shared with the frame buffer write port
//   gpu_rst_n  : asynchronous active-low reset
//   bus        : fb_write_scheduler_if.slave carrying both request channels,
//                clear control, frame buffer write port and drop counter
//
// Timing:
//   - ready is combinational (ready = grant); a transfer accepted at an edge
//     appears on fb_we/fb_addr/fb_data in the following cycle.
//   - clr_start in IDLE starts H_RES*V_RES consecutive write cycles beginning
//     the cycle after clr_start; clr_done marks the final write.
// -----------------------------------------------------------------------------
module fb_write_scheduler #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 4,
    parameter int X_W    = 9,
    parameter int Y_W    = 8
) (
    input  logic                 gpu_clk,
    input  logic                 gpu_rst_n,
    fb_write_scheduler_if.slave  bus
);

    localparam int N_REQ    = 2;
    localparam int REQ_RAST = 0;
    localparam int REQ_HOST = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(H_RES);
    localparam logic [X_W-1:0]    X_LIMIT     = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_LIMIT     = Y_W'(V_RES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    // Index of the requester granted most recently; resets to host so the
    // rasterizer wins the first tie.
    logic              last_grant_q, last_grant_d;
    logic              fb_we_q, fb_we_d;
    // During a clear fb_addr_q doubles as the clear counter: the address on
    // the port is exactly the pixel being cleared this cycle.
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]  fb_data_q, fb_data_d;
    logic [PIX_W-1:0]  clr_color_q, clr_color_d;
    logic              clr_done_q, clr_done_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // -------------------------------------------------------------------------
    // Requester view as arrays so both channels share one piece of logic
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0]  req_valid;
    logic [X_W-1:0]    req_x     [N_REQ];
    logic [Y_W-1:0]    req_y     [N_REQ];
    logic [PIX_W-1:0]  req_color [N_REQ];

    assign req_valid[REQ_RAST] = bus.rast_valid;
    assign req_x[REQ_RAST]     = bus.rast_x;
    assign req_y[REQ_RAST]     = bus.rast_y;
    assign req_color[REQ_RAST] = bus.rast_color;

    assign req_valid[REQ_HOST] = bus.host_valid;
    assign req_x[REQ_HOST]     = bus.host_x;
    assign req_y[REQ_HOST]     = bus.host_y;
    assign req_color[REQ_HOST] = bus.host_color;

    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  req_in_range;
    logic [ADDR_W-1:0] req_addr [N_REQ];
    logic              arb_open;

    // Arbitration is closed for the clr_start cycle itself and for the whole
    // clear, so no request can be accepted and then lost to the sequencer.
    assign arb_open = (state_q == ST_IDLE) && !bus.clr_start;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_req
        localparam logic [0:0] OTHER_IDX = 1'(N_REQ - 1 - gi);

        assign req_in_range[gi] = (req_x[gi] < X_LIMIT) && (req_y[gi] < Y_LIMIT);

        // Full ADDR_W product: 239*320+319 = 76799 fits without truncation.
        assign req_addr[gi] = ADDR_W'(req_y[gi]) * ADDR_STRIDE + ADDR_W'(req_x[gi]);

        // Granted if valid and either alone or not the most recent winner.
        assign grant[gi] = arb_open && req_valid[gi] &&
                           (!req_valid[OTHER_IDX] || (last_grant_q == OTHER_IDX));
    end

    // Selected request (only meaningful when xfer is high).
    logic              xfer;
    logic [0:0]        sel_idx;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [PIX_W-1:0]  sel_color;

    assign xfer         = |grant;
    assign sel_idx      = grant[REQ_HOST];
    assign sel_in_range = req_in_range[sel_idx];
    assign sel_addr     = req_addr[sel_idx];
    assign sel_color    = req_color[sel_idx];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clr_color_d  = clr_color_q;
        clr_done_d   = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    // First clear write (address 0) goes out next cycle.
                    state_d     = ST_CLEAR;
                    clr_color_d = bus.clr_color;
                    fb_we_d     = 1'b1;
                    fb_addr_d   = '0;
                    fb_data_d   = bus.clr_color;
                end else if (xfer) begin
                    last_grant_d = grant[REQ_HOST];
                    if (sel_in_range) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = sel_addr;
                        fb_data_d = sel_color;
                    end else if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end

            ST_CLEAR: begin
                if (fb_addr_q == CLR_LAST) begin
                    // Final write is on the port now; arbitration resumes next.
                    state_d = ST_IDLE;
                end else begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = fb_addr_q + ADDR_W'(1);
                    fb_data_d  = clr_color_q;
                    clr_done_d = (fb_addr_q == CLR_LAST - ADDR_W'(1));
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
        if (!gpu_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clr_color_q  <= '0;
            clr_done_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            clr_color_q  <= clr_color_d;
            clr_done_q   <= clr_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gated by reset so readys are low while reset is held, whatever valid does.
    assign bus.rast_ready = grant[REQ_RAST] & gpu_rst_n;
    assign bus.host_ready = grant[REQ_HOST] & gpu_rst_n;

    assign bus.clr_busy = (state_q == ST_CLEAR);
    assign bus.clr_done = clr_done_q;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fb_write_scheduler
//
// Self-checking bench for fb_write_scheduler. Inputs are driven on the falling
// edge; registered outputs are sampled on the falling edge and the
// combinational readys 1 ns after the inputs settle. Randomised traffic is
// checked against a frame-level model that applies the arbitration, address
// and drop rules directly.
// -----------------------------------------------------------------------------
module tb_fb_write_scheduler;

    localparam int H = 320;
    localparam int V = 240;
    localparam int NPIX = H * V;

    logic clk;
    logic rst_n;

    fb_write_scheduler_if bus ();

    fb_write_scheduler dut (
        .gpu_clk   (clk),
        .gpu_rst_n (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic m_last_host;   // 1 when the host won the most recent transfer
    int   m_drop;
    logic m_we;
    int   m_addr;
    int   m_data;

    function automatic logic [1:0] exp_grant(input logic rv, input logic hv);
        // bit0 = rast, bit1 = host
        if (rv && hv) return m_last_host ? 2'b01 : 2'b10;
        if (rv)       return 2'b01;
        if (hv)       return 2'b10;
        return 2'b00;
    endfunction

    // Apply the effect of the transfer granted at this edge.
    task automatic model_xfer(input logic [1:0] g);
        int x, y, c;
        if (g == 2'b00) begin
            m_we = 1'b0;
            return;
        end
        x = g[1] ? int'(bus.host_x) : int'(bus.rast_x);
        y = g[1] ? int'(bus.host_y) : int'(bus.rast_y);
        c = g[1] ? int'(bus.host_color) : int'(bus.rast_color);
        m_last_host = g[1];
        if (x < H && y < V) begin
            m_we   = 1'b1;
            m_addr = y * H + x;
            m_data = c;
        end else begin
            m_we = 1'b0;
            if (m_drop < 65535) m_drop++;
        end
        $display("xfer %s x=%0d y=%0d c=%0h %s", g[1] ? "host" : "rast", x, y, c,
                 (x < H && y < V) ? "write" : "drop");
    endtask

    task automatic idle_inputs();
        bus.rast_valid = 1'b0; bus.rast_x = '0; bus.rast_y = '0; bus.rast_color = '0;
        bus.host_valid = 1'b0; bus.host_x = '0; bus.host_y = '0; bus.host_color = '0;
        bus.clr_start  = 1'b0; bus.clr_color = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last_host = 1'b1;
        m_drop = 0; m_we = 1'b0; m_addr = 0; m_data = 0;
    endtask

    function automatic logic [8:0] rand_x();
        case ($urandom_range(0, 7))
            0: return 9'd0;
            1: return 9'd319;
            2: return 9'd320;
            3: return 9'd511;
            default: return 9'($urandom_range(0, 359));
        endcase
    endfunction

    function automatic logic [7:0] rand_y();
        case ($urandom_range(0, 7))
            0: return 8'd0;
            1: return 8'd239;
            2: return 8'd240;
            3: return 8'd255;
            default: return 8'($urandom_range(0, 263));
        endcase
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        bus.rast_valid = 1'b1; bus.host_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (bus.rast_ready !== 1'b0) $display("FAIL reset_rast_ready got %0b want 0", bus.rast_ready); else n_pass++;
        n_checks++; if (bus.host_ready !== 1'b0) $display("FAIL reset_host_ready got %0b want 0", bus.host_ready); else n_pass++;
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL reset_fb_we got %0b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd0) $display("FAIL reset_fb_addr got %0d want 0", bus.fb_addr); else n_pass++;
        n_checks++; if (bus.fb_data !== 4'd0) $display("FAIL reset_fb_data got %0h want 0", bus.fb_data); else n_pass++;
        n_checks++; if (bus.clr_busy !== 1'b0) $display("FAIL reset_clr_busy got %0b want 0", bus.clr_busy); else n_pass++;
        n_checks++; if (bus.clr_done !== 1'b0) $display("FAIL reset_clr_done got %0b want 0", bus.clr_done); else n_pass++;
        n_checks++; if (bus.drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); else n_pass++;
        bus.rast_valid = 1'b0; bus.host_valid = 1'b0;
        do_reset();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        do_reset();
        @(negedge clk);
        bus.rast_valid = 1'b1; bus.rast_x = 9'd5; bus.rast_y = 8'd2; bus.rast_color = 4'hA;
        #1;
        n_checks++; if (bus.rast_ready !== 1'b1) $display("FAIL single_ready got %0b want 1", bus.rast_ready); else n_pass++;
        @(posedge clk);
        model_xfer(exp_grant(1'b1, 1'b0));
        @(negedge clk);
        bus.rast_valid = 1'b0;
        n_checks++; if (bus.fb_we !== 1'b1) $display("FAIL single_we got %0b want 1", bus.fb_we); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd645) $display("FAIL single_addr got %0d want 645", bus.fb_addr); else n_pass++;
        n_checks++; if (bus.fb_data !== 4'hA) $display("FAIL single_data got %0h want a", bus.fb_data); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL single_we_after got %0b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd645) $display("FAIL single_addr_hold got %0d want 645", bus.fb_addr); else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++; if (bus.fb_we !== 1'b1) $display("FAIL alt_we[%0d] got %0b want 1", i, bus.fb_we); else n_pass++;
                n_checks++;
                if (bus.fb_addr !== (((i - 1) % 2 == 0) ? 17'd321 : 17'd962))
                    $display("FAIL alt_addr[%0d] got %0d want %0d", i, bus.fb_addr, ((i - 1) % 2 == 0) ? 321 : 962);
                else n_pass++;
            end
            bus.rast_valid = 1'b1; bus.rast_x = 9'd1; bus.rast_y = 8'd1; bus.rast_color = 4'h1;
            bus.host_valid = 1'b1; bus.host_x = 9'd2; bus.host_y = 8'd3; bus.host_color = 4'h2;
            #1;
            n_checks++; if (bus.rast_ready !== (i % 2 == 0)) $display("FAIL alt_rast_ready[%0d] got %0b want %0b", i, bus.rast_ready, i % 2 == 0); else n_pass++;
            n_checks++; if (bus.host_ready !== (i % 2 == 1)) $display("FAIL alt_host_ready[%0d] got %0b want %0b", i, bus.host_ready, i % 2 == 1); else n_pass++;
            @(posedge clk);
            model_xfer(exp_grant(1'b1, 1'b1));
        end
        @(negedge clk);
        bus.rast_valid = 1'b0; bus.host_valid = 1'b0;
        n_checks++; if (bus.fb_data !== 4'h2) $display("FAIL alt_last_data got %0h want 2", bus.fb_data); else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_range();
        do_reset();
        @(negedge clk);
        bus.host_valid = 1'b1; bus.host_x = 9'd320; bus.host_y = 8'd0; bus.host_color = 4'h1;
        #1;
        n_checks++; if (bus.host_ready !== 1'b1) $display("FAIL range_ready_oob got %0b want 1", bus.host_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL range_we_oob got %0b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.drop_cnt !== 16'd1) $display("FAIL range_drop got %0d want 1", bus.drop_cnt); else n_pass++;
        bus.host_x = 9'd319; bus.host_y = 8'd239; bus.host_color = 4'h7;
        #1;
        n_checks++; if (bus.host_ready !== 1'b1) $display("FAIL range_ready_edge got %0b want 1", bus.host_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.host_valid = 1'b0;
        n_checks++; if (bus.fb_we !== 1'b1) $display("FAIL range_we_edge got %0b want 1", bus.fb_we); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd76799) $display("FAIL range_addr_edge got %0d want 76799", bus.fb_addr); else n_pass++;
        n_checks++; if (bus.fb_data !== 4'h7) $display("FAIL range_data_edge got %0h want 7", bus.fb_data); else n_pass++;
        n_checks++; if (bus.drop_cnt !== 16'd1) $display("FAIL range_drop_hold got %0d want 1", bus.drop_cnt); else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        logic [1:0] g;
        g = 2'b00;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks++; if (bus.fb_we !== m_we) $display("FAIL rnd_we[%0d] got %0b want %0b", i, bus.fb_we, m_we); else n_pass++;
            n_checks++; if (bus.fb_addr !== 17'(m_addr)) $display("FAIL rnd_addr[%0d] got %0d want %0d", i, bus.fb_addr, m_addr); else n_pass++;
            n_checks++; if (bus.fb_data !== 4'(m_data)) $display("FAIL rnd_data[%0d] got %0h want %0h", i, bus.fb_data, m_data); else n_pass++;
            n_checks++; if (bus.drop_cnt !== 16'(m_drop)) $display("FAIL rnd_drop[%0d] got %0d want %0d", i, bus.drop_cnt, m_drop); else n_pass++;
            // A requester left waiting keeps its request unchanged.
            if (!(bus.rast_valid && !g[0])) begin
                bus.rast_valid = ($urandom_range(0, 3) != 0);
                bus.rast_x = rand_x(); bus.rast_y = rand_y(); bus.rast_color = 4'($urandom_range(0, 15));
            end
            if (!(bus.host_valid && !g[1])) begin
                bus.host_valid = ($urandom_range(0, 3) != 0);
                bus.host_x = rand_x(); bus.host_y = rand_y(); bus.host_color = 4'($urandom_range(0, 15));
            end
            #1;
            g = exp_grant(bus.rast_valid, bus.host_valid);
            n_checks++;
            if ({bus.host_ready, bus.rast_ready} !== g)
                $display("FAIL rnd_ready[%0d] got host=%0b rast=%0b want %02b", i, bus.host_ready, bus.rast_ready, g);
            else n_pass++;
            @(posedge clk);
            model_xfer(g);
        end
        @(negedge clk);
        bus.rast_valid = 1'b0; bus.host_valid = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Full clear with a rasterizer request held throughout and a second
    // clr_start (different color) pulsed mid-clear.
    task automatic test_clear();
        int bad, first_bad, done_cnt, ready_seen;
        logic done_last;
        bad = 0; first_bad = -1; done_cnt = 0; ready_seen = 0; done_last = 1'b0;
        do_reset();
        @(negedge clk);
        bus.rast_valid = 1'b1; bus.rast_x = 9'd4; bus.rast_y = 8'd0; bus.rast_color = 4'h5;
        bus.clr_start = 1'b1; bus.clr_color = 4'h3;
        #1;
        n_checks++; if (bus.rast_ready !== 1'b0) $display("FAIL clr_start_ready got %0b want 0", bus.rast_ready); else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            bus.clr_start = (k == 500);
            bus.clr_color = (k == 500) ? 4'h9 : 4'h3;
            if (!(bus.clr_busy === 1'b1 && bus.fb_we === 1'b1 &&
                  bus.fb_addr === 17'(k) && bus.fb_data === 4'h3)) begin
                if (first_bad < 0) begin
                    first_bad = k;
                    $display("clear cycle %0d: busy=%0b we=%0b addr=%0d data=%0h", k,
                             bus.clr_busy, bus.fb_we, bus.fb_addr, bus.fb_data);
                end
                bad++;
            end
            if (bus.clr_done === 1'b1) begin
                done_cnt++;
                if (k == NPIX - 1) done_last = 1'b1;
            end
            #1;
            if (bus.rast_ready !== 1'b0 || bus.host_ready !== 1'b0) ready_seen++;
        end
        $display("clear: %0d cycles, %0d bad writes, %0d done pulses", NPIX, bad, done_cnt);
        n_checks++; if (bad != 0) $display("FAIL clr_writes got %0d bad (first at %0d) want 0", bad, first_bad); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL clr_done_count got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (done_last !== 1'b1) $display("FAIL clr_done_at_last got %0b want 1", done_last); else n_pass++;
        n_checks++; if (ready_seen != 0) $display("FAIL clr_ready_blocked got %0d ready cycles want 0", ready_seen); else n_pass++;
        @(negedge clk);
        bus.clr_start = 1'b0;
        n_checks++; if (bus.clr_busy !== 1'b0) $display("FAIL clr_busy_end got %0b want 0", bus.clr_busy); else n_pass++;
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL clr_we_end got %0b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.clr_done !== 1'b0) $display("FAIL clr_done_end got %0b want 0", bus.clr_done); else n_pass++;
        #1;
        n_checks++; if (bus.rast_ready !== 1'b1) $display("FAIL clr_rast_after got %0b want 1", bus.rast_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.rast_valid = 1'b0;
        n_checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd4 || bus.fb_data !== 4'h5)
            $display("FAIL clr_rast_write got we=%0b addr=%0d data=%0h want 1/4/5", bus.fb_we, bus.fb_addr, bus.fb_data);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_clear();
        int stray;
        stray = 0;
        do_reset();
        @(negedge clk);
        bus.clr_start = 1'b1; bus.clr_color = 4'h3;
        @(negedge clk);
        bus.clr_start = 1'b0;
        repeat (1000) @(negedge clk);
        n_checks++; if (bus.fb_addr !== 17'd1000) $display("FAIL rstmid_addr got %0d want 1000", bus.fb_addr); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.fb_we !== 1'b0) $display("FAIL rstmid_we got %0b want 0", bus.fb_we); else n_pass++;
        n_checks++; if (bus.clr_busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", bus.clr_busy); else n_pass++;
        n_checks++; if (bus.clr_done !== 1'b0) $display("FAIL rstmid_done got %0b want 0", bus.clr_done); else n_pass++;
        n_checks++; if (bus.fb_addr !== 17'd0) $display("FAIL rstmid_addr_clr got %0d want 0", bus.fb_addr); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.fb_we !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL rstmid_abandoned got %0d active cycles want 0", stray); else n_pass++;
        bus.clr_start = 1'b1; bus.clr_color = 4'hC;
        @(negedge clk);
        bus.clr_start = 1'b0;
        n_checks++;
        if (bus.clr_busy !== 1'b1 || bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd0 || bus.fb_data !== 4'hC)
            $display("FAIL rstmid_restart0 got busy=%0b we=%0b addr=%0d data=%0h want 1/1/0/c",
                     bus.clr_busy, bus.fb_we, bus.fb_addr, bus.fb_data);
        else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.fb_addr !== 17'd1) $display("FAIL rstmid_restart1 got %0d want 1", bus.fb_addr); else n_pass++;
        $display("reset mid-clear: restart from address 0 observed at %0d", bus.fb_addr);
        do_reset();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_range();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
Write-side controller for the frame buffer's GPU write port (we/addr/data, 320x240, 4-bit pixels). It arbitrates pixel writes between the rasterizer and a host port using round-robin with valid/ready handshakes. It converts (x,y) coordinates to linear addresses. It also contains a full-screen clear sequencer that owns the write port while active.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
ADDR_W, 17, frame buffer address width
PIX_W, 4, pixel data width
X_W, 9, x coordinate width
Y_W, 8, y coordinate width

Ports:
gpu_clk  in  1  clock, shared with the frame buffer write port
gpu_rst_n  in  1  asynchronous active-low reset
rast_valid  in  1  rasterizer write request
rast_ready  out  1  rasterizer request accepted this cycle
rast_x  in  X_W  rasterizer x
rast_y  in  Y_W  rasterizer y
rast_color  in  PIX_W  rasterizer pixel value
host_valid  in  1  host write request
host_ready  out  1  host request accepted this cycle
host_x  in  X_W  host x
host_y  in  Y_W  host y
host_color  in  PIX_W  host pixel value
clr_start  in  1  start full-screen clear (sampled one cycle)
clr_color  in  PIX_W  fill value, latched with clr_start
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse on final clear write
fb_we  out  1  to frame buffer gpu_we
fb_addr  out  ADDR_W  to frame buffer gpu_pixel_addr
fb_data  out  PIX_W  to frame buffer gpu_pixel_data
drop_cnt  out  16  count of out-of-range requests dropped

Behaviour:
- Clock and reset: one clock, gpu_clk. Reset gpu_rst_n is asynchronous, active-low.
- Reset values:
  - fb_we, fb_addr, fb_data, clr_busy, clr_done, drop_cnt are all 0.
  - State is IDLE.
  - Round-robin pointer is set so rast wins the first tie.
  - rast_ready and host_ready are forced 0 while gpu_rst_n is low.
- States:
  - IDLE: arbitration is active.
  - CLEAR: sequencer owns the port.
- IDLE arbitration:
  - Grant goes only to a requester whose valid is high. If one is valid, it is granted. If both are valid, the one not granted last is granted.
  - ready is combinational: ready = grant. It may depend on valid. A transfer occurs on valid & ready at a clock edge.
  - Both readys are 0 in any cycle where clr_start is high or clr_busy is high.
- Write latency: a transfer accepted at edge N drives fb_we=1, fb_addr, and fb_data in the cycle after N (registered outputs).
  - fb_we is 0 in cycles with no transfer. fb_addr and fb_data hold their last values.
- Address: addr = y*H_RES + x, computed at ADDR_W width with no truncation (maximum 76799).
- Out of range (x>=H_RES or y>=V_RES):
  - The handshake completes normally and the round-robin pointer advances.
  - No write is issued.
  - drop_cnt increments by 1, saturating at 0xFFFF.
- IDLE->CLEAR: clr_start sampled high in IDLE latches clr_color and resets the counter to 0.
- CLEAR:
  - clr_busy is high for exactly H_RES*V_RES cycles, beginning the cycle after clr_start.
  - Each of those cycles has fb_we=1, fb_addr equal to the counter (0,1,…,76799), and fb_data equal to the latched color.
  - clr_done=1 only in the cycle fb_addr=76799. The state returns to IDLE after that cycle.
  - The earliest arbitrated transfer is the edge ending the first cycle after clr_busy falls.
- clr_start while busy is ignored; the clear does not restart and the color does not change.
- Reset mid-operation: every output clears immediately. A pending clear is abandoned with no clr_done. An in-flight arbitrated write is discarded.
- Requesters must hold valid and payload stable until ready. The scheduler does not check this.

Test Plan:
1. Reset, then rast_valid with x=5, y=2, color 0xA -> rast_ready=1 in the same cycle. Next cycle fb_we=1, fb_addr=645, fb_data=0xA. Cycle after that fb_we=0.
2. rast_valid and host_valid held high with distinct coordinates -> accepts alternate rast,host,rast,host, with rast first after reset. fb_we=1 on every cycle after the first accept.
3. host x=320, y=0 -> host_ready=1, no fb_we, drop_cnt=1. Then host x=319, y=239, color 0x7 -> fb_addr=76799, fb_data=0x7, drop_cnt stays 1.
4. clr_start with clr_color=0x3 while rast_valid is held -> rast_ready=0 for the clr_start cycle and all 76800 busy cycles. fb_addr runs contiguously 0..76799 with data 0x3, and clr_done is a single pulse at 76799. rast is accepted one cycle after clr_busy falls.
5. gpu_rst_n driven low at clear cycle 1000 -> fb_we, clr_busy, clr_done go 0 asynchronously, with no clr_done ever. After release, a new clr_start restarts at fb_addr=0.
6. clr_start re-pulsed with clr_color=0x9 at busy cycle 500 -> ignored. Exactly 76800 writes occur, all with data 0x3, and one clr_done.
